// File: rtl/pim_pkg.sv
// Shared definitions for the PIM input path.
// Holds the mode encodings, the vector geometry, the input-buffer FSM state type
// and the small helpers used by the buffer and its fill bank.
package pim_pkg;

    // PIM operating modes
    localparam logic [2:0] PIM_READ     = 3'b001;
    localparam logic [2:0] PIM_PARALLEL = 3'b101;
    localparam logic [2:0] PIM_RBR      = 3'b110;

    // Vector geometry: 32 words of 32 bits, word 0 is the MSB word
    localparam int unsigned PIM_WORDS  = 32;
    localparam int unsigned PIM_WORD_W = 32;
    localparam int unsigned PIM_VEC_W  = PIM_WORDS * PIM_WORD_W;
    localparam int unsigned PIM_IDX_W  = $clog2(PIM_WORDS);
    localparam int unsigned PIM_LVL_W  = $clog2(PIM_WORDS) + 1;

    // Input-buffer FSM
    typedef enum logic [1:0] {
        StEmpty,
        StFilling,
        StFull
    } pim_buf_state_e;

    // Number of set bits in a word-valid mask
    function automatic logic [PIM_LVL_W-1:0] popcount(input logic [PIM_WORDS-1:0] mask);
        logic [PIM_LVL_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PIM_WORDS; i++) begin
            cnt = cnt + PIM_LVL_W'(mask[i]);
        end
        return cnt;
    endfunction

    // Modes in which the buffer accepts word stores
    function automatic logic mode_is_store(input logic [2:0] mode);
        return (mode == PIM_PARALLEL) || (mode == PIM_RBR);
    endfunction

endpackage

// File: rtl/input_buffer_bank.sv
// Fill bank for the PIM input buffer.
// Stores up to 32 words, keeps a per-word written mask and reports how many
// distinct words have been written.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears the mask only)
//   clear_i        drop all written-word marks (flush or hand-off to shadow)
//   wr_en_i        write wr_data_i into word wr_idx_i and mark it written
//   wr_idx_i       word index, 0 = MSB word of data_o
//   wr_data_i      word to write
//   data_o         assembled vector, word i at bits [VEC_W-1-32*i -: 32]
//   mask_o         per-word written flags, bit i = word i
//   fill_level_o   population count of mask_o
module input_buffer_bank
    import pim_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [PIM_IDX_W-1:0]  wr_idx_i,
    input  logic [PIM_WORD_W-1:0] wr_data_i,
    output logic [PIM_VEC_W-1:0]  data_o,
    output logic [PIM_WORDS-1:0]  mask_o,
    output logic [PIM_LVL_W-1:0]  fill_level_o
);

    logic [PIM_WORD_W-1:0] word_q [PIM_WORDS];
    logic [PIM_WORDS-1:0]  mask_q;
    logic [PIM_WORDS-1:0]  mask_d;

    // Word storage needs no reset: a vector is only handed off once every word
    // has been rewritten since the last clear.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            word_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (clear_i) begin
            mask_d = '0;
        end else if (wr_en_i) begin
            mask_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    for (genvar w = 0; w < PIM_WORDS; w++) begin : g_word
        assign data_o[PIM_VEC_W-1-w*PIM_WORD_W -: PIM_WORD_W] = word_q[w];
    end

    assign mask_o       = mask_q;
    assign fill_level_o = popcount(mask_q);

endmodule

// File: rtl/pim_input_buffer.sv
// PIM input buffer.
// Collects 32 words into a fill bank, then copies the complete vector into a
// shadow register that is presented to the PIM array with a valid/ready
// handshake. The fill bank can refill while the shadow is waiting.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   pim_mode_i           current PIM mode; stores accepted in PARALLEL or RBR only
//   store_en_i           word store request
//   store_cnt_i          down-counting word counter, word index = 31 - store_cnt_i
//   store_data_i         word to store
//   store_ready_o        a store can be accepted this cycle (fill bank not full)
//   flush_i              discard fill bank, pending vector and overflow flag
//   pim_input_o          vector from the shadow register
//   pim_input_valid_o    pim_input_o holds a complete vector
//   pim_input_ready_i    PIM array consumes the vector
//   fill_level_o         distinct words written into the fill bank
//   overflow_o           sticky: a store was dropped while the bank was full
module pim_input_buffer
    import pim_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2:0]            pim_mode_i,
    input  logic                  store_en_i,
    input  logic [PIM_IDX_W-1:0]  store_cnt_i,
    input  logic [PIM_WORD_W-1:0] store_data_i,
    output logic                  store_ready_o,
    input  logic                  flush_i,
    output logic [PIM_VEC_W-1:0]  pim_input_o,
    output logic                  pim_input_valid_o,
    input  logic                  pim_input_ready_i,
    output logic [PIM_LVL_W-1:0]  fill_level_o,
    output logic                  overflow_o
);

    pim_buf_state_e        state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;
    logic [PIM_VEC_W-1:0]  shadow_q, shadow_d;

    logic                  mode_ok;
    logic                  accept;
    logic                  drop;
    logic                  transfer;
    logic                  completes;
    logic [PIM_IDX_W-1:0]  word_idx;
    logic [PIM_VEC_W-1:0]  bank_data;
    logic [PIM_WORDS-1:0]  bank_mask;
    logic [PIM_LVL_W-1:0]  bank_level;

    assign word_idx      = PIM_IDX_W'(PIM_WORDS - 1) - store_cnt_i;
    assign mode_ok       = mode_is_store(pim_mode_i);
    assign store_ready_o = (state_q != StFull);

    // Flush outranks everything, so a store in a flush cycle is not written.
    assign accept = store_en_i && store_ready_o && mode_ok && !flush_i;
    assign drop   = store_en_i && !store_ready_o && mode_ok;

    // Last missing word arriving: the bank becomes full at this edge.
    assign completes = accept && !bank_mask[word_idx] &&
                       (bank_level == PIM_LVL_W'(PIM_WORDS - 1));

    // Hand the full bank to the shadow when the shadow is free or being consumed.
    assign transfer = (state_q == StFull) && (!valid_q || pim_input_ready_i) && !flush_i;

    input_buffer_bank u_bank (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (flush_i || transfer),
        .wr_en_i      (accept),
        .wr_idx_i     (word_idx),
        .wr_data_i    (store_data_i),
        .data_o       (bank_data),
        .mask_o       (bank_mask),
        .fill_level_o (bank_level)
    );

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty:   if (accept)    state_d = StFilling;
                StFilling: if (completes) state_d = StFull;
                StFull:    if (transfer)  state_d = StEmpty;
                default:                  state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        shadow_d   = shadow_q;
        valid_d    = valid_q;
        overflow_d = overflow_q || drop;
        if (flush_i) begin
            valid_d    = 1'b0;
            overflow_d = 1'b0;
        end else if (transfer) begin
            // A reload on the consuming edge keeps valid high back-to-back.
            shadow_d = bank_data;
            valid_d  = 1'b1;
        end else if (valid_q && pim_input_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StEmpty;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            shadow_q   <= shadow_d;
        end
    end

    assign pim_input_o       = shadow_q;
    assign pim_input_valid_o = valid_q;
    assign overflow_o        = overflow_q;
    assign fill_level_o      = bank_level;

endmodule

// File: tb/tb_pim_input_buffer.sv
module tb_pim_input_buffer;
    import pim_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [2:0]   pim_mode_i;
    logic         store_en_i;
    logic [4:0]   store_cnt_i;
    logic [31:0]  store_data_i;
    logic         store_ready_o;
    logic         flush_i;
    logic [1023:0] pim_input_o;
    logic         pim_input_valid_o;
    logic         pim_input_ready_i;
    logic [5:0]   fill_level_o;
    logic         overflow_o;

    int checks = 0;
    int failures = 0;
    logic [1023:0] exp_q[$];

    pim_input_buffer dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .pim_mode_i        (pim_mode_i),
        .store_en_i        (store_en_i),
        .store_cnt_i       (store_cnt_i),
        .store_data_i      (store_data_i),
        .store_ready_o     (store_ready_o),
        .flush_i           (flush_i),
        .pim_input_o       (pim_input_o),
        .pim_input_valid_o (pim_input_valid_o),
        .pim_input_ready_i (pim_input_ready_i),
        .fill_level_o      (fill_level_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_v(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_s(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] make_vec(input logic [31:0] base);
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) begin
            v[1023-32*i -: 32] = base + 32'(i);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic store(input logic [4:0] cnt, input logic [31:0] data);
        store_en_i   = 1'b1;
        store_cnt_i  = cnt;
        store_data_i = data;
        tick();
        store_en_i   = 1'b0;
    endtask

    // Word index i carries base+i, issued with store_cnt 31 down to 0.
    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 32; i++) begin
            store(5'(31 - i), base + 32'(i));
        end
    endtask

    // Scoreboard monitor: every consumed vector must match the oldest expected one.
    always @(negedge clk_i) begin
        if (!rst_i && pim_input_valid_o && pim_input_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_vector: got %0h expected none", pim_input_o);
            end else begin
                check_v("vector", pim_input_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1023:0] v;
        logic          seen;

        rst_i = 1'b1;
        pim_mode_i = 3'b000;
        store_en_i = 1'b0;
        store_cnt_i = '0;
        store_data_i = '0;
        flush_i = 1'b0;
        pim_input_ready_i = 1'b0;
        tick();
        tick();
        check_s("rst_valid", 32'(pim_input_valid_o), 32'd0);
        check_s("rst_fill", 32'(fill_level_o), 32'd0);
        check_s("rst_overflow", 32'(overflow_o), 32'd0);
        check_s("rst_ready", 32'(store_ready_o), 32'd1);
        check_v("rst_vec", pim_input_o, '0);
        rst_i = 1'b0;
        tick();

        // Mode 101, ready held high: single vector, valid for one cycle.
        pim_mode_i = 3'b101;
        pim_input_ready_i = 1'b1;
        exp_q.push_back(make_vec(32'h1000_0000));
        fill(32'h1000_0000);
        check_s("s1_ready_full", 32'(store_ready_o), 32'd0);
        check_s("s1_fill_32", 32'(fill_level_o), 32'd32);
        check_s("s1_valid_n", 32'(pim_input_valid_o), 32'd0);
        tick();
        check_s("s1_valid_n1", 32'(pim_input_valid_o), 32'd1);
        check_s("s1_word0", pim_input_o[1023:992], 32'h1000_0000);
        check_s("s1_word31", pim_input_o[31:0], 32'h1000_001F);
        check_s("s1_ready_empty", 32'(store_ready_o), 32'd1);
        tick();
        check_s("s1_valid_n2", 32'(pim_input_valid_o), 32'd0);

        // Mode 110, ready low: two fills, overflow, back-to-back drain.
        pim_mode_i = 3'b110;
        pim_input_ready_i = 1'b0;
        exp_q.push_back(make_vec(32'h2000_0000));
        fill(32'h2000_0000);
        tick();
        check_s("s2_valid_first", 32'(pim_input_valid_o), 32'd1);
        check_v("s2_vec_first", pim_input_o, make_vec(32'h2000_0000));
        fill(32'h3000_0000);
        tick();
        check_s("s2_ready_full", 32'(store_ready_o), 32'd0);
        check_s("s2_fill_32", 32'(fill_level_o), 32'd32);
        check_v("s2_vec_stable", pim_input_o, make_vec(32'h2000_0000));
        check_s("s2_overflow_pre", 32'(overflow_o), 32'd0);
        store(5'd0, 32'hDEAD_BEEF);
        check_s("s2_overflow", 32'(overflow_o), 32'd1);
        exp_q.push_back(make_vec(32'h3000_0000));
        pim_input_ready_i = 1'b1;
        tick();
        check_s("s2_valid_cont", 32'(pim_input_valid_o), 32'd1);
        check_v("s2_vec_second", pim_input_o, make_vec(32'h3000_0000));
        tick();
        check_s("s2_valid_done", 32'(pim_input_valid_o), 32'd0);
        check_s("s2_overflow_sticky", 32'(overflow_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_s("s2_overflow_flush", 32'(overflow_o), 32'd0);

        // Repeated store to index 5.
        pim_mode_i = 3'b101;
        v = make_vec(32'h4000_0000);
        v[863:832] = 32'h5555_5555;
        exp_q.push_back(v);
        store(5'd26, 32'hAAAA_AAAA);
        check_s("s3_fill_once", 32'(fill_level_o), 32'd1);
        store(5'd26, 32'h5555_5555);
        check_s("s3_fill_twice", 32'(fill_level_o), 32'd1);
        for (int i = 0; i < 32; i++) begin
            if (i != 5) store(5'(31 - i), 32'h4000_0000 + 32'(i));
        end
        tick();
        check_s("s3_word5", pim_input_o[863:832], 32'h5555_5555);
        tick();

        // Mode 011: stores ignored.
        pim_mode_i = 3'b011;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            store(5'(31 - i), 32'h9000_0000 + 32'(i));
            seen = seen | pim_input_valid_o;
        end
        tick();
        seen = seen | pim_input_valid_o;
        check_s("s4_fill", 32'(fill_level_o), 32'd0);
        check_s("s4_no_valid", 32'(seen), 32'd0);
        check_s("s4_overflow", 32'(overflow_o), 32'd0);

        // Partial fill then flush; next full fill yields exactly one vector.
        pim_mode_i = 3'b101;
        for (int i = 0; i < 20; i++) begin
            store(5'(31 - i), 32'h5000_0000 + 32'(i));
        end
        check_s("s5_fill_20", 32'(fill_level_o), 32'd20);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_s("s5_fill_flush", 32'(fill_level_o), 32'd0);
        check_s("s5_overflow_flush", 32'(overflow_o), 32'd0);
        exp_q.push_back(make_vec(32'h6000_0000));
        fill(32'h6000_0000);
        tick();
        tick();
        tick();
        check_s("s5_overflow_after", 32'(overflow_o), 32'd0);
        check_s("s5_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset during the 17th store.
        pim_input_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            store(5'(31 - i), 32'h7000_0000 + 32'(i));
        end
        rst_i = 1'b1;
        store(5'd15, 32'h7000_0010);
        rst_i = 1'b0;
        check_s("s6a_fill", 32'(fill_level_o), 32'd0);
        check_s("s6a_valid", 32'(pim_input_valid_o), 32'd0);
        check_s("s6a_ready", 32'(store_ready_o), 32'd1);
        check_v("s6a_vec", pim_input_o, '0);

        // Reset with a vector pending; it must never be delivered.
        fill(32'h8000_0000);
        tick();
        check_s("s6b_valid_pending", 32'(pim_input_valid_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_s("s6b_valid", 32'(pim_input_valid_o), 32'd0);
        check_s("s6b_fill", 32'(fill_level_o), 32'd0);
        check_s("s6b_overflow", 32'(overflow_o), 32'd0);
        check_s("s6b_ready", 32'(store_ready_o), 32'd1);
        check_v("s6b_vec", pim_input_o, '0);
        pim_input_ready_i = 1'b1;
        tick();
        tick();
        tick();
        pim_input_ready_i = 1'b0;

        check_s("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pim_input_buffer.md
PIM_INPUT_BUFFER -- requirements
Module: pim_input_buffer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk_i input 1 is the clock; rst_i input 1 is the synchronous active-high reset.
REQ-002 The block SHALL provide these remaining ports:
- pim_mode_i  input  3  current PIM mode
- store_en_i  input  1  word store request
- store_cnt_i  input  5  down-counting word counter; word index = 31 - store_cnt_i
- store_data_i  input  32  word to store
- store_ready_o  output  1  store can be accepted this cycle
- flush_i  input  1  discard the fill bank and the shadow register
- pim_input_o  output  1024  assembled vector to the PIM array
- pim_input_valid_o  output  1  pim_input_o holds a complete vector
- pim_input_ready_i  input  1  PIM array consumes the vector
- fill_level_o  output  6  count of distinct words written into the fill bank
- overflow_o  output  1  sticky flag: a store was dropped

Function
REQ-003 A store SHALL be accepted when store_en_i=1, store_ready_o=1 and pim_mode_i is PIM_PARALLEL (3'b101) or PIM_RBR (3'b110); stores in any other mode SHALL be ignored without side effects.
REQ-004 An accepted store with word index i SHALL write store_data_i into fill-bank bits [1023-32*i -: 32] and set mask bit i; word 0 is the MSB word.
REQ-005 A repeated store to an already-set index SHALL overwrite the data and SHALL leave the mask and fill_level_o unchanged.
REQ-006 fill_level_o SHALL equal the population count of the mask, range 0..32.
REQ-007 The FSM SHALL have three states:
- EMPTY: mask = 0
- FILLING: 0 < mask < all-ones
- FULL: mask = all-ones
Transitions are EMPTY->FILLING on first accept, FILLING->FULL on the 32nd distinct word, and FULL->EMPTY on transfer.
REQ-008 store_ready_o SHALL equal (state != FULL).
REQ-009 A store attempted while store_ready_o=0 in a valid mode SHALL be dropped and SHALL set overflow_o; overflow_o SHALL clear only on flush_i or rst_i.
REQ-010 In FULL, the block SHALL copy the fill bank to the shadow register at the next edge when the shadow is free (pim_input_valid_o=0) or is being consumed that cycle (pim_input_valid_o=1 and pim_input_ready_i=1); the same edge SHALL clear the mask, and state SHALL become EMPTY.
REQ-011 Latency SHALL be as follows when the shadow is free: last store accepted at edge N, pim_input_valid_o high after edge N+1.
REQ-012 pim_input_o SHALL be driven from the shadow register only, and SHALL stay stable while pim_input_valid_o=1 and pim_input_ready_i=0.
REQ-013 pim_input_valid_o SHALL clear on the edge where pim_input_ready_i=1, unless a transfer reloads the shadow on that same edge, in which case it SHALL stay high.
REQ-014 A store accepted in the same cycle as a transfer SHALL NOT occur, because store_ready_o=0 in FULL.
REQ-015 flush_i SHALL take priority over store, transfer and handshake: it clears the mask, state, pim_input_valid_o and overflow_o at the next edge, and the shadow data need not be cleared.
REQ-016 pim_mode_i changes while in FILLING SHALL preserve the partial fill; the fill resumes when the mode returns to PARALLEL or RBR.

Reset
REQ-017 With rst_i=1 sampled at an edge, the block SHALL set: state EMPTY, mask 0, pim_input_valid_o 0, overflow_o 0, fill_level_o 0, and pim_input_o 0.
REQ-018 After reset, store_ready_o SHALL be 1.
REQ-019 Reset asserted mid-fill or mid-handshake SHALL discard all partial and pending data without emitting a valid vector.

Structure
REQ-020 The mode constants PIM_READ, PIM_PARALLEL and PIM_RBR, plus PIM_WORDS=32, PIM_WORD_W=32 and the FSM state enum, SHALL live in the shared pim_pkg.
REQ-021 The fill-bank storage plus mask plus popcount SHALL be one sub-module, input_buffer_bank; FSM, shadow and handshake logic SHALL stay in pim_input_buffer.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Mode 101: store words store_cnt 31..0 with data 0x1000_0000+i, ready held 1 -> valid pulses one cycle 2 edges after last store, with pim_input_o[1023:992]=0x1000_0000 and [31:0]=0x1000_001F.
- Mode 110: fill twice while ready=0 -> first vector held stable; second fill reaches FULL with store_ready_o=0; an extra store sets overflow_o=1; ready=1 for 2 cycles -> back-to-back vectors with valid continuous.
- Store index 5 twice (0xAAAA_AAAA then 0x5555_5555) -> fill_level_o=1, and the final vector word 5 = 0x5555_5555.
- Mode 011: 32 stores -> fill_level_o stays 0, valid never asserts.
- 20 stores in mode 101, then flush_i -> fill_level_o=0, overflow_o=0; the next 32 stores produce exactly one vector.
- rst_i asserted at store 17 and at pending valid -> all outputs 0 and store_ready_o=1 the next cycle.
